// File: rtl/regfile_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_reader_if
// Description : Bundle of the register-file read port signals: writeback
//               load port, rs1/rs2 request handshake and operand response
//               handshake. The master is the decode/writeback side and the
//               slave is regfile_reader.
// Revision    : 1.0  initial release
// ============================================================================
interface regfile_reader_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;

  modport master (
    output wr_en, wr_addr, wr_data, req_valid, rs1, rs2, rsp_ready,
    input  req_ready, rsp_valid, rs1_data, rs2_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, req_valid, rs1, rs2, rsp_ready,
    output req_ready, rsp_valid, rs1_data, rs2_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_reader
// Description : Read side of the general register file. Accepts rs1/rs2
//               read requests, snapshots both operands from storage and
//               queues them in a 2-entry output FIFO so decode runs at full
//               rate while execute may stall. Register 0 reads as zero.
//               Optional macro REGFILE_BYPASS_EN forwards a same-cycle
//               writeback into the captured operands.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_reader #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int DW   = 32
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  regfile_reader_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          req_ready_q;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] head_rs1_q, head_rs1_d;
  logic [DW-1:0] head_rs2_q, head_rs2_d;
  logic [DW-1:0] tail_rs1_q, tail_rs1_d;
  logic [DW-1:0] tail_rs2_q, tail_rs2_d;

  logic          w_wr_hit;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;

  assign w_wr_hit = bus.wr_en && (bus.wr_addr != '0);
  assign w_push   = bus.req_valid && req_ready_q;
  assign w_pop    = (state_q != ST_EMPTY) && bus.rsp_ready;

  // Storage array; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_hit) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Operand values captured on accept, optionally forwarding the writeback.
  always_comb begin
    w_op1 = regs_q[bus.rs1];
    w_op2 = regs_q[bus.rs2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_hit && (bus.wr_addr == bus.rs1)) begin
      w_op1 = bus.wr_data;
    end
    if (w_wr_hit && (bus.wr_addr == bus.rs2)) begin
      w_op2 = bus.wr_data;
    end
`endif
  end

  // Occupancy FSM and FIFO entry movement.
  always_comb begin
    state_d    = state_q;
    head_rs1_d = head_rs1_q;
    head_rs2_d = head_rs2_q;
    tail_rs1_d = tail_rs1_q;
    tail_rs2_d = tail_rs2_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_push) begin
          state_d    = ST_ONE;
          head_rs1_d = w_op1;
          head_rs2_d = w_op2;
        end
      end
      ST_ONE: begin
        if (w_push && w_pop) begin
          head_rs1_d = w_op1;
          head_rs2_d = w_op2;
        end else if (w_push) begin
          state_d    = ST_TWO;
          tail_rs1_d = w_op1;
          tail_rs2_d = w_op2;
        end else if (w_pop) begin
          // Head keeps its value so the outputs hold while rsp_valid is low.
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          state_d    = ST_ONE;
          head_rs1_d = tail_rs1_q;
          head_rs2_d = tail_rs2_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State, FIFO entries and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      req_ready_q <= 1'b1;
      head_rs1_q  <= '0;
      head_rs2_q  <= '0;
      tail_rs1_q  <= '0;
      tail_rs2_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d != ST_TWO);
      head_rs1_q  <= head_rs1_d;
      head_rs2_q  <= head_rs2_d;
      tail_rs1_q  <= tail_rs1_d;
      tail_rs2_q  <= tail_rs2_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = (state_q != ST_EMPTY);
  assign bus.rs1_data  = head_rs1_q;
  assign bus.rs2_data  = head_rs2_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_reader
// Description : Self-checking bench for regfile_reader: vector table for the
//               basic read/write paths plus directed streaming,
//               back-pressure and asynchronous reset sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_reader;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  regfile_reader_if #(.AW(5), .DW(32)) bus ();

  regfile_reader #(.NREG(32), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] X7_SAME = 32'h12345678;
`else
  localparam logic [31:0] X7_SAME = 32'h00000001;
`endif

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        req_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rsp_ready;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [4:0] a1, input logic [4:0] a2,
                       input logic rr);
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.req_valid = rv;
    bus.rs1       = a1;
    bus.rs2       = a2;
    bus.rsp_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic er,
                           input logic [31:0] e1, input logic [31:0] e2);
    check({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, {31'd0, ev});
    check({tag, ".req_ready"}, {31'd0, bus.req_ready}, {31'd0, er});
    check({tag, ".rs1_data"}, bus.rs1_data, e1);
    check({tag, ".rs2_data"}, bus.rs2_data, e2);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);

    //        we    wa     wd            rv    rs1    rs2    rr    ev    er    e_rs1         e_rs2
    tbl[0] = '{1'b1, 5'd5, 32'haaaabbbb, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 32'haaaabbbb, 32'h0};
    tbl[2] = '{1'b1, 5'd0, 32'hffffffff, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'haaaabbbb, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 32'h0,        32'haaaabbbb};
    tbl[4] = '{1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0,        32'haaaabbbb};
    tbl[5] = '{1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, X7_SAME,      X7_SAME};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, X7_SAME,      X7_SAME};
    tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'haaaabbbb};

    // Reset state
    #12;
    check_out("reset", 1'b0, 1'b1, 32'h0, 32'h0);
    rst_n = 1'b1;
    step();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data, tbl[i].req_valid,
            tbl[i].rs1, tbl[i].rs2, tbl[i].rsp_ready);
      step();
      check_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_ready, tbl[i].e_rs1, tbl[i].e_rs2);
    end

    // Preload x10..x17 while draining the buffer
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(10 + i), 32'h10000000 + 32'(i), 1'b0, 5'd0, 5'd0, 1'b1);
      step();
    end
    check("drained.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Stream 8 back-to-back requests with execute always ready
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(10 + i), 5'(17 - i), 1'b1);
      step();
      check_out($sformatf("stream%0d", i), 1'b1, 1'b1,
                32'h10000000 + 32'(i), 32'h10000000 + 32'(7 - i));
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    step();
    check("stream_end.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Back-pressure with snapshot: preload x1..x4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h11111111 * 32'(i), 1'b0, 5'd0, 5'd0, 1'b1);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2, 1'b0);
    step();
    check_out("bp_a", 1'b1, 1'b1, 32'h11111111, 32'h22222222);
    drive(1'b1, 5'd1, 32'hdead0001, 1'b1, 5'd3, 5'd4, 1'b0);
    step();
    check_out("bp_b", 1'b1, 1'b0, 32'h11111111, 32'h22222222);
    drive(1'b1, 5'd3, 32'hdead0003, 1'b1, 5'd1, 5'd1, 1'b0);
    step();
    check_out("bp_c", 1'b1, 1'b0, 32'h11111111, 32'h22222222);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    step();
    check_out("bp_pop1", 1'b1, 1'b1, 32'h33333333, 32'h44444444);
    step();
    check_out("bp_pop2", 1'b0, 1'b1, 32'h33333333, 32'h44444444);
    // Third request was refused; snapshot writes still reached storage
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd3, 1'b1);
    step();
    check_out("bp_after", 1'b1, 1'b1, 32'hdead0001, 32'hdead0003);

    // Asynchronous reset while the buffer is full
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7, 1'b0);
    step();
    step();
    check("full.req_ready", {31'd0, bus.req_ready}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 1'b1, 32'h0, 32'h0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7, 1'b1);
    step();
    check_out("post_rst", 1'b1, 1'b1, 32'h0, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd17, 1'b1);
    step();
    check_out("post_rst2", 1'b1, 1'b1, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
